// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Issues one data-memory transaction per MEM-stage load/store and stalls the
// pipeline while that transaction is outstanding. It lane-shifts store data
// and strobes, and returns the aligned, sign/zero-extended load result.
// Optional feature: define LSU_MISALIGN_CHECK_EN to complete misaligned
// accesses locally with misalign_o=1 and no bus request.
module mem_stage_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic        mem_we_i,
   input  logic [1:0]  mem_size_i,
   input  logic        mem_signed_i,
   input  logic [63:0] mem_addr_i,
   input  logic [63:0] mem_wdata_i,
   input  logic        stage_stall_i,
   input  logic        stage_flush_i,
   output logic        ram_stall_valid_mem_o,
   output logic [63:0] load_data_o,
   output logic        access_fault_o,
   output logic        misalign_o,
   output logic        req_valid_o,
   input  logic        req_ready_i,
   output logic [63:0] req_addr_o,
   output logic        req_we_o,
   output logic [1:0]  req_size_o,
   output logic [63:0] req_wdata_o,
   output logic [7:0]  req_wstrb_o,
   input  logic        rsp_valid_i,
   input  logic [63:0] rsp_rdata_i,
   input  logic        rsp_err_i
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DRAIN, S_DONE} state_t;

   state_t      state_reg;
   logic [63:0] addr_reg;
   logic [1:0]  size_reg;
   logic        we_reg;
   logic        signed_reg;
   logic [63:0] wdata_reg;
   logic [7:0]  wstrb_reg;
   logic        req_valid_reg;
   logic [63:0] load_data_reg;
   logic        fault_reg;

   logic [2:0]  in_off;
   logic [3:0]  in_nbytes;
   logic [7:0]  in_strb;
   logic [63:0] in_wdata_sh;
   logic [63:0] rsp_shift;
   logic [63:0] ext_data;

   assign in_off      = mem_addr_i[2:0];
   assign in_nbytes   = 4'd1 << mem_size_i;
   assign in_wdata_sh = mem_wdata_i << {in_off, 3'b000};

   // Per-lane strobe: lane is enabled when it falls inside [off, off+nbytes);
   // lanes past 7 simply do not exist, which truncates the access.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign in_strb[gi] = (4'(gi) >= {1'b0, in_off}) &&
                              (4'(gi) <  ({1'b0, in_off} + in_nbytes));
      end
   endgenerate

`ifdef LSU_MISALIGN_CHECK_EN
   logic in_misaligned;
   logic misalign_reg;
   assign in_misaligned = (in_off & (in_nbytes[2:0] - 3'd1)) != 3'd0;
   assign misalign_o    = misalign_reg;
`else
   assign misalign_o    = 1'b0;
`endif

   // Align the returned lane word to bit 0 and extend to the access size.
   always_comb begin
      rsp_shift = rsp_rdata_i >> {addr_reg[2:0], 3'b000};
      ext_data  = rsp_shift;
      case (size_reg)
         2'd0:    ext_data = {{56{signed_reg & rsp_shift[7]}},  rsp_shift[7:0]};
         2'd1:    ext_data = {{48{signed_reg & rsp_shift[15]}}, rsp_shift[15:0]};
         2'd2:    ext_data = {{32{signed_reg & rsp_shift[31]}}, rsp_shift[31:0]};
         default: ext_data = rsp_shift;
      endcase
   end

   // Stall request is combinational so the controller holds the pipeline in the
   // very cycle a new access shows up in MEM.
   assign ram_stall_valid_mem_o = ((state_reg == S_IDLE) && mem_valid_i && !stage_flush_i) ||
                                  (state_reg == S_REQ) || (state_reg == S_WAIT_RSP) ||
                                  (state_reg == S_DRAIN);

   assign req_valid_o    = req_valid_reg;
   assign req_addr_o     = addr_reg;
   assign req_we_o       = we_reg;
   assign req_size_o     = size_reg;
   assign req_wdata_o    = wdata_reg;
   assign req_wstrb_o    = wstrb_reg;
   assign load_data_o    = load_data_reg;
   assign access_fault_o = fault_reg;

   // Transaction FSM with registered request fields and results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         addr_reg      <= '0;
         size_reg      <= '0;
         we_reg        <= 1'b0;
         signed_reg    <= 1'b0;
         wdata_reg     <= '0;
         wstrb_reg     <= '0;
         req_valid_reg <= 1'b0;
         load_data_reg <= '0;
         fault_reg     <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
         misalign_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (mem_valid_i && !stage_flush_i) begin
                  // Clear old results so a flushed access can never show them.
                  load_data_reg <= '0;
                  fault_reg     <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                  misalign_reg  <= in_misaligned;
                  if (in_misaligned) begin
                     state_reg <= S_DONE;
                  end else begin
`else
                  begin
`endif
                     addr_reg      <= mem_addr_i;
                     size_reg      <= mem_size_i;
                     we_reg        <= mem_we_i;
                     signed_reg    <= mem_signed_i;
                     wdata_reg     <= in_wdata_sh;
                     wstrb_reg     <= mem_we_i ? in_strb : 8'h00;
                     req_valid_reg <= 1'b1;
                     state_reg     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (req_ready_i) begin
                  // Once the bus has taken the request its response must be
                  // consumed, so a flush in the accept cycle drains instead.
                  req_valid_reg <= 1'b0;
                  state_reg     <= stage_flush_i ? S_DRAIN : S_WAIT_RSP;
               end else if (stage_flush_i) begin
                  req_valid_reg <= 1'b0;
                  state_reg     <= S_IDLE;
               end
            end
            S_WAIT_RSP: begin
               if (stage_flush_i) begin
                  // A response arriving with the flush is already consumed.
                  state_reg <= rsp_valid_i ? S_IDLE : S_DRAIN;
               end else if (rsp_valid_i) begin
                  fault_reg     <= rsp_err_i;
                  load_data_reg <= (rsp_err_i || we_reg) ? 64'd0 : ext_data;
                  state_reg     <= S_DONE;
               end
            end
            S_DRAIN: begin
               if (rsp_valid_i) state_reg <= S_IDLE;
            end
            S_DONE: begin
               if (stage_flush_i || !stage_stall_i) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table vectors, hand sequences for flush/reset/hold corner
// cases, and random transactions against a byte-level reference model.
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i, mem_we_i, mem_signed_i;
   logic [1:0]  mem_size_i;
   logic [63:0] mem_addr_i, mem_wdata_i;
   logic        stage_stall_i, stage_flush_i;
   logic        ram_stall_valid_mem_o;
   logic [63:0] load_data_o;
   logic        access_fault_o, misalign_o;
   logic        req_valid_o, req_ready_i, req_we_o;
   logic [63:0] req_addr_o, req_wdata_o;
   logic [1:0]  req_size_o;
   logic [7:0]  req_wstrb_o;
   logic        rsp_valid_i, rsp_err_i;
   logic [63:0] rsp_rdata_i;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
      .mem_signed_i(mem_signed_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .stage_stall_i(stage_stall_i), .stage_flush_i(stage_flush_i),
      .ram_stall_valid_mem_o(ram_stall_valid_mem_o), .load_data_o(load_data_o),
      .access_fault_o(access_fault_o), .misalign_o(misalign_o),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
      .req_we_o(req_we_o), .req_size_o(req_size_o), .req_wdata_o(req_wdata_o),
      .req_wstrb_o(req_wstrb_o), .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
      .rsp_err_i(rsp_err_i)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        err;
      int          rdy;
      int          rsp;
      logic [63:0] exp_ld;
      logic        exp_fault;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      logic        exp_mis;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn_no);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic err, input int rdy,
                               input int rsp, input logic [63:0] exp_ld, input logic exp_fault,
                               input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                               input logic exp_mis);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.err = err; v.rdy = rdy; v.rsp = rsp; v.exp_ld = exp_ld;
      v.exp_fault = exp_fault; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
      v.exp_mis = exp_mis;
      return v;
   endfunction

   // Reference model: works byte by byte from the access width and offset.
   function automatic vec_t model(input vec_t v);
      vec_t        r = v;
      int          n = 1 << v.size;
      int          off = int'(v.addr[2:0]);
      logic [31:0] s;
      logic [63:0] val = 64'd0;
      s = ((32'd1 << n) - 32'd1) << off;
      r.exp_strb  = v.we ? s[7:0] : 8'h00;
      r.exp_wdata = v.wdata << (8 * off);
      for (int k = 0; k < n; k++)
         if (off + k < 8) val[8*k +: 8] = v.rdata[8*(off+k) +: 8];
      if (v.sgn && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      r.exp_ld    = (v.we || v.err) ? 64'd0 : val;
      r.exp_fault = v.err;
`ifdef LSU_MISALIGN_CHECK_EN
      r.exp_mis   = (off % n) != 0;
`else
      r.exp_mis   = 1'b0;
`endif
      if (r.exp_mis) begin
         r.exp_ld = 64'd0;
         r.exp_fault = 1'b0;
      end
      return r;
   endfunction

   task automatic set_mem(input vec_t v);
      mem_valid_i = 1'b1; mem_we_i = v.we; mem_size_i = v.size; mem_signed_i = v.sgn;
      mem_addr_i = v.addr; mem_wdata_i = v.wdata;
   endtask

   // Drives one complete access; caller and task both sit 1 time unit after a clock edge.
   task automatic run_txn(input vec_t v, input int hold);
      txn_no++;
      set_mem(v);
      #1;
      chk("c0_stall", ram_stall_valid_mem_o, 1);
      chk("c0_req_valid", req_valid_o, 0);
      @(posedge clk); #1;
      if (v.exp_mis) begin
         chk("mis_flag", misalign_o, 1);
         chk("mis_req_valid", req_valid_o, 0);
         chk("mis_stall", ram_stall_valid_mem_o, 0);
         chk("mis_fault", access_fault_o, 0);
         @(posedge clk); #1;
         mem_valid_i = 1'b0;
      end else begin
         for (int d = 0; d <= v.rdy; d++) begin
            req_ready_i = (d == v.rdy);
            #1;
            chk("req_valid", req_valid_o, 1);
            chk("req_addr", req_addr_o, v.addr);
            chk("req_we", req_we_o, v.we);
            chk("req_size", req_size_o, v.size);
            chk("req_wstrb", req_wstrb_o, v.exp_strb);
            if (v.we) chk("req_wdata", req_wdata_o, v.exp_wdata);
            chk("req_stall", ram_stall_valid_mem_o, 1);
            @(posedge clk); #1;
         end
         req_ready_i = 1'b0;
         for (int d = 0; d <= v.rsp; d++) begin
            rsp_valid_i = (d == v.rsp); rsp_rdata_i = v.rdata; rsp_err_i = v.err;
            #1;
            chk("wait_stall", ram_stall_valid_mem_o, 1);
            chk("wait_req_valid", req_valid_o, 0);
            @(posedge clk); #1;
         end
         rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
         for (int h = 0; h <= hold; h++) begin
            stage_stall_i = (h < hold);
            #1;
            chk("done_stall", ram_stall_valid_mem_o, 0);
            chk("done_req_valid", req_valid_o, 0);
            chk("done_fault", access_fault_o, v.exp_fault);
            chk("done_misalign", misalign_o, 0);
            if (!v.we) chk("done_load_data", load_data_o, v.exp_ld);
            @(posedge clk); #1;
         end
         stage_stall_i = 1'b0;
         mem_valid_i = 1'b0;
      end
      $display("txn %0d: we=%0d size=%0d sgn=%0d addr=%h ld=%h fault=%0d mis=%0d hold=%0d",
               txn_no, v.we, v.size, v.sgn, v.addr, load_data_o, access_fault_o, misalign_o, hold);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; mem_valid_i = 0; mem_we_i = 0; mem_size_i = 0; mem_signed_i = 0;
      mem_addr_i = 0; mem_wdata_i = 0; stage_stall_i = 0; stage_flush_i = 0;
      req_ready_i = 0; rsp_valid_i = 0; rsp_err_i = 0; rsp_rdata_i = 0;

      tbl.push_back(mk(0, 2, 1, 64'h8000_0004, 0, 64'h8765_4321_0000_0000, 0, 0, 0,
                       64'hFFFF_FFFF_8765_4321, 0, 8'h00, 64'h0, 0));
      tbl.push_back(mk(1, 0, 0, 64'h1000_0003, 64'hAB, 0, 0, 3, 0,
                       64'h0, 0, 8'h08, 64'h0000_0000_AB00_0000, 0));
`ifdef LSU_MISALIGN_CHECK_EN
      tbl.push_back(mk(0, 1, 0, 64'h0000_0101, 0, 64'h1234, 0, 0, 0,
                       64'h0, 0, 8'h00, 64'h0, 1));
`else
      tbl.push_back(mk(1, 3, 0, 64'h0000_1004, 64'h1122_3344_5566_7788, 0, 0, 0, 0,
                       64'h0, 0, 8'hF0, 64'h5566_7788_0000_0000, 0));
`endif
      tbl.push_back(mk(0, 0, 0, 64'h7, 0, 64'h8100_0000_0000_0000, 0, 1, 0,
                       64'h81, 0, 8'h00, 64'h0, 0));
      tbl.push_back(mk(0, 0, 1, 64'h7, 0, 64'h8100_0000_0000_0000, 0, 0, 1,
                       64'hFFFF_FFFF_FFFF_FF81, 0, 8'h00, 64'h0, 0));
      tbl.push_back(mk(0, 1, 1, 64'h2, 0, 64'h0000_0000_7FFE_0000, 0, 0, 0,
                       64'h7FFE, 0, 8'h00, 64'h0, 0));
      tbl.push_back(mk(0, 1, 1, 64'hA, 0, 64'h0000_0000_C001_1234, 0, 2, 0,
                       64'hFFFF_FFFF_FFFF_C001, 0, 8'h00, 64'h0, 0));
      tbl.push_back(mk(0, 3, 1, 64'h10, 0, 64'h8000_0000_0000_0001, 0, 0, 0,
                       64'h8000_0000_0000_0001, 0, 8'h00, 64'h0, 0));
      tbl.push_back(mk(0, 2, 0, 64'h8, 0, 64'hDEAD_BEEF_DEAD_BEEF, 1, 0, 2,
                       64'h0, 1, 8'h00, 64'h0, 0));
      tbl.push_back(mk(1, 1, 0, 64'h6, 64'hBEEF, 0, 0, 0, 0,
                       64'h0, 0, 8'hC0, 64'hBEEF_0000_0000_0000, 0));
      tbl.push_back(mk(1, 2, 0, 64'h0, 64'h1234_5678, 0, 1, 1, 1,
                       64'h0, 1, 8'h0F, 64'h0000_0000_1234_5678, 0));
      tbl.push_back(mk(0, 2, 0, 64'h4, 0, 64'h8765_4321_0000_0000, 0, 0, 0,
                       64'h8765_4321, 0, 8'h00, 64'h0, 0));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", ram_stall_valid_mem_o, 0);
      chk("rst_req_valid", req_valid_o, 0);
      chk("rst_req_addr", req_addr_o, 0);
      chk("rst_req_wdata", req_wdata_o, 0);
      chk("rst_req_wstrb", req_wstrb_o, 0);
      chk("rst_req_we", req_we_o, 0);
      chk("rst_req_size", req_size_o, 0);
      chk("rst_load_data", load_data_o, 0);
      chk("rst_fault", access_fault_o, 0);
      chk("rst_misalign", misalign_o, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) run_txn(tbl[i], 0);

      // DONE held by the controller for 5 cycles: no reissue, data held
      run_txn(tbl[0], 5);

      // Flush in WAIT_RSP, then an error response while draining
      v = mk(0, 2, 0, 64'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      txn_no++;
      set_mem(v);
      @(posedge clk); #1;
      req_ready_i = 1'b1;
      @(posedge clk); #1;
      req_ready_i = 1'b0; stage_flush_i = 1'b1;
      #1;
      chk("flushw_stall", ram_stall_valid_mem_o, 1);
      @(posedge clk); #1;
      stage_flush_i = 1'b0; mem_valid_i = 1'b0;
      #1;
      chk("drain_stall", ram_stall_valid_mem_o, 1);
      chk("drain_req_valid", req_valid_o, 0);
      @(posedge clk); #1;
      rsp_valid_i = 1'b1; rsp_err_i = 1'b1; rsp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk("drain_rsp_stall", ram_stall_valid_mem_o, 1);
      @(posedge clk); #1;
      rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
      #1;
      chk("drain_idle_stall", ram_stall_valid_mem_o, 0);
      chk("drain_fault", access_fault_o, 0);
      chk("drain_load_data", load_data_o, 0);
      $display("txn %0d: flush in WAIT_RSP, error response drained", txn_no);
      run_txn(tbl[4], 0);

      // Flush while the request is still unaccepted
      txn_no++;
      set_mem(tbl[1]);
      @(posedge clk); #1;
      stage_flush_i = 1'b1;
      #1;
      chk("flushr_req_valid", req_valid_o, 1);
      @(posedge clk); #1;
      stage_flush_i = 1'b0; mem_valid_i = 1'b0;
      #1;
      chk("flushr_dropped", req_valid_o, 0);
      chk("flushr_stall", ram_stall_valid_mem_o, 0);
      $display("txn %0d: flush in REQ, request dropped", txn_no);
      run_txn(tbl[5], 0);

      // Reset in the middle of a transaction
      txn_no++;
      set_mem(tbl[0]);
      @(posedge clk); #1;
      req_ready_i = 1'b1;
      @(posedge clk); #1;
      req_ready_i = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mem_valid_i = 1'b0;
      #1;
      chk("mrst_stall", ram_stall_valid_mem_o, 0);
      chk("mrst_req_valid", req_valid_o, 0);
      chk("mrst_load_data", load_data_o, 0);
      $display("txn %0d: reset during WAIT_RSP", txn_no);
      run_txn(tbl[7], 0);

      // Random transactions against the model
      for (int i = 0; i < 40; i++) begin
         v.we = 1'($urandom_range(0, 1));
         v.size = 2'($urandom_range(0, 3));
         v.sgn = 1'($urandom_range(0, 1));
         v.addr = {$urandom(), $urandom()};
         v.wdata = {$urandom(), $urandom()};
         v.rdata = {$urandom(), $urandom()};
         v.err = ($urandom_range(0, 7) == 0);
         v.rdy = $urandom_range(0, 3);
         v.rsp = $urandom_range(0, 3);
         v = model(v);
         run_txn(v, $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

MEM-stage load/store unit that issues data-memory transactions and raises the MEM RAM stall request consumed by the pipeline controller. It sits between the EX_MEM pipeline register and the data-memory bus, holds the pipeline while a transaction is outstanding, and returns aligned, extended load data to the MEM_WB register. It honours the controller's EX_MEM stall bit and MEM-stage flush so no access is issued twice or lost.

## Interface
- XLEN, 64, data/address width; fixed 64 in this design (8 byte lanes).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_valid_i  in  1  instruction in MEM stage is a load/store.
- mem_we_i  in  1  1 store, 0 load.
- mem_size_i  in  2  0 byte, 1 half, 2 word, 3 dword.
- mem_signed_i  in  1  load sign-extends when 1.
- mem_addr_i  in  XLEN  byte address.
- mem_wdata_i  in  XLEN  store data, right-justified.
- stage_stall_i  in  1  controller stall bit 4 (EX_MEM held).
- stage_flush_i  in  1  controller flush for the MEM-stage instruction.
- ram_stall_valid_mem_o  out  1  stall request to pipeline controller.
- load_data_o  out  XLEN  extended load result, valid in DONE.
- access_fault_o  out  1  bus error on completed access, valid in DONE.
- misalign_o  out  1  misaligned access detected, valid in DONE.
- req_valid_o  out  1  bus request valid.
- req_ready_i  in  1  bus accepts request.
- req_addr_o  out  XLEN  request address.
- req_we_o  out  1  write request.
- req_size_o  out  2  access size.
- req_wdata_o  out  XLEN  lane-shifted store data.
- req_wstrb_o  out  8  byte-lane enables (0 for loads).
- rsp_valid_i  in  1  response valid (accepted unconditionally).
- rsp_rdata_i  in  XLEN  read data, full 64-bit lane word.
- rsp_err_i  in  1  response error.

## Operation
- States: IDLE, REQ, WAIT_RSP, DRAIN, DONE.
- IDLE: mem_valid_i=1 and stage_flush_i=0 -> REQ (latch addr/size/we/signed/wdata); else stay.
- REQ: req_valid_o=1 with latched fields; req_ready_i=1 -> WAIT_RSP. Fields stable while unaccepted.
- WAIT_RSP: rsp_valid_i=1 -> DONE, capture rdata/err.
- DONE: stall low, results held. stage_stall_i=1 -> stay DONE (no reissue); else -> IDLE.
- ram_stall_valid_mem_o = (IDLE & mem_valid_i & ~stage_flush_i) | REQ | WAIT_RSP | DRAIN; combinational.
- Flush: in REQ -> IDLE, request dropped (req_valid_o low next cycle); in WAIT_RSP -> DRAIN; in DRAIN, rsp_valid_i -> IDLE, response discarded, no fault reported; in DONE -> IDLE.
- Lane rules: off = addr[2:0]; wstrb = ((1<<(1<<size))-1) << off, bits beyond 7 dropped; wdata = wdata << (8*off).
- Load: shift rdata right 8*off, keep 8/16/32/64 bits, sign- or zero-extend to XLEN; dword ignores signed.
- access_fault_o = captured rsp_err_i; load_data_o forced 0 when fault.

## Timing
- Reset: state IDLE; all outputs 0 (req_*, load_data_o, flags, stall).
- Reset mid-transaction: IDLE next cycle; bus shares rst, no drain.
- Minimum load latency, ready and response both immediate: c0 IDLE stall=1; c1 REQ accepted; c2 WAIT_RSP rsp; c3 DONE stall=0, data valid. 4 cycles MEM occupancy.
- Each extra ready or response wait cycle adds one cycle.
- Response in the same cycle as acceptance is not permitted; bus responds ≥1 cycle after.
- Only one outstanding transaction.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: access with addr not a multiple of (1<<size) goes IDLE -> DONE directly, no bus request, misalign_o=1, stall high for the IDLE cycle only.
- Undefined: misalign_o tied 0; misaligned access issued as-is with lane truncation above.

## Test plan
- Load word signed, addr 0x8000_0004, rdata 0x8765_4321_0000_0000, immediate ready/rsp -> load_data_o=0xFFFF_FFFF_8765_4321 at c3, stall high c0-c2.
- Store byte addr 0x...03, wdata 0xAB, ready delayed 3 cycles -> req_wstrb_o=0x08, req_wdata_o bits[31:24]=0xAB, fields stable 4 cycles, stall high throughout.
- DONE with stage_stall_i=1 for 5 cycles -> no second req_valid_o, load_data_o held, then IDLE.
- stage_flush_i in WAIT_RSP, rsp_err_i=1 -> DRAIN, response discarded, access_fault_o stays 0, back to IDLE.
- rsp_err_i=1 on load -> DONE with access_fault_o=1, load_data_o=0.
- LSU_MISALIGN_CHECK_EN: half load addr 0x...01 -> no req_valid_o, misalign_o=1 next cycle; undefined: wstrb for dword store at off 4 = 0xF0.
